// File: rtl/fetch_pkg.sv
// Shared constants, default parameters and width helpers for the fetch queue.
package fetch_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_FETCH_W = 2;
  localparam int unsigned DEF_ISSUE_W = 2;

  // Encoding presented on lanes that hold no valid instruction
  localparam logic [DEF_DATA_W-1:0] NOP = '0;

  // Bits needed to index n entries (at least one bit)
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count from 0 to n inclusive
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side push bus and decode-side issue bus of the fetch queue.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned FETCH_W = DEF_FETCH_W,
  parameter int unsigned ISSUE_W = DEF_ISSUE_W
) ();

  logic [FETCH_W-1:0]          in_valid;
  logic [FETCH_W*DATA_W-1:0]   in_instr;
  logic [FETCH_W*DATA_W-1:0]   in_pc;
  logic                        in_ready;
  logic [ISSUE_W-1:0]          out_valid;
  logic [ISSUE_W*DATA_W-1:0]   out_instr;
  logic [ISSUE_W*DATA_W-1:0]   out_pc;
  logic [cnt_w(ISSUE_W)-1:0]   out_take;
  logic [cnt_w(DEPTH)-1:0]     count;

  modport master (
    output in_valid, in_instr, in_pc, out_take,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_take,
    output in_ready, out_valid, out_instr, out_pc, count
  );

endinterface

// File: rtl/fetch_queue_rotate.sv
// Head-aligned read mux: lane i shows entry (head + i), masked to NOP beyond occupancy.
module fetch_queue_rotate
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned ISSUE_W = DEF_ISSUE_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] i_instr,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_pc,
  input  logic [ptr_w(DEPTH)-1:0]      i_head,
  input  logic [cnt_w(DEPTH)-1:0]      i_count,
  output logic [ISSUE_W-1:0]           o_valid,
  output logic [ISSUE_W*DATA_W-1:0]    o_instr,
  output logic [ISSUE_W*DATA_W-1:0]    o_pc
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  // Select head-relative entries; pointer add wraps naturally at DEPTH
  always_comb begin
    o_valid = '0;
    o_instr = {ISSUE_W{DATA_W'(NOP)}};
    o_pc    = '0;
    for (int i = 0; i < int'(ISSUE_W); i++) begin
      if (i_count > CNT_W'(i)) begin
        o_valid[i]                 = 1'b1;
        o_instr[i*DATA_W +: DATA_W] = i_instr[i_head + PTR_W'(i)];
        o_pc[i*DATA_W +: DATA_W]    = i_pc[i_head + PTR_W'(i)];
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane instruction fetch queue between fetch and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned FETCH_W = DEF_FETCH_W,
  parameter int unsigned ISSUE_W = DEF_ISSUE_W
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         FREEZE,
  input  logic         flush,
  fetch_queue_if.slave fq
);

  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam int unsigned LANE_W = cnt_w(FETCH_W);

  logic [DEPTH-1:0][DATA_W-1:0] r_instr;
  logic [DEPTH-1:0][DATA_W-1:0] r_pc;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;

  logic [LANE_W-1:0] w_prefix;
  logic [LANE_W-1:0] w_push_n;
  logic              w_run;
  logic              w_ready;
  logic [CNT_W-1:0]  w_space;
  logic [CNT_W-1:0]  w_avail;
  logic [CNT_W-1:0]  w_take;
  logic [CNT_W-1:0]  w_pop_n;

  // Length of the contiguous valid run starting at lane 0
  always_comb begin
    w_prefix = '0;
    w_run    = 1'b1;
    for (int i = 0; i < int'(FETCH_W); i++) begin
      w_run = w_run & fq.in_valid[i];
      if (w_run) w_prefix = w_prefix + LANE_W'(1);
    end
  end

  // Ready looks only at pre-pop occupancy so it never depends on out_take
  assign w_space  = CNT_W'(DEPTH) - r_count;
  assign w_ready  = RESET & ~FREEZE & ~flush & (w_space >= CNT_W'(FETCH_W));
  assign w_push_n = w_ready ? w_prefix : '0;

  // Pop clipped to both the issue width and the current occupancy
  assign w_avail = (r_count < CNT_W'(ISSUE_W)) ? r_count : CNT_W'(ISSUE_W);
  assign w_take  = CNT_W'(fq.out_take);
  assign w_pop_n = (FREEZE | flush) ? '0 : ((w_take < w_avail) ? w_take : w_avail);

  // Head, tail and occupancy; flush outranks FREEZE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (!FREEZE) begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + CNT_W'(w_push_n) - w_pop_n;
    end
  end

  // Write accepted lanes at the tail in lane order; storage is never reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(FETCH_W); i++) begin
      if (LANE_W'(i) < w_push_n) begin
        r_instr[r_tail + PTR_W'(i)] <= fq.in_instr[i*DATA_W +: DATA_W];
        r_pc[r_tail + PTR_W'(i)]    <= fq.in_pc[i*DATA_W +: DATA_W];
      end
    end
  end

  fetch_queue_rotate #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_rotate (
    .i_instr (r_instr),
    .i_pc    (r_pc),
    .i_head  (r_head),
    .i_count (r_count),
    .o_valid (fq.out_valid),
    .o_instr (fq.out_instr),
    .o_pc    (fq.out_pc)
  );

  assign fq.in_ready = w_ready;
  assign fq.count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=8, FETCH_W=ISSUE_W=2, DATA_W=32).
module tb_fetch_queue;

  logic CLK;
  logic RESET;
  logic FREEZE;
  logic flush;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   m_pop;
  bit   m_room;

  fetch_queue_if #(.DATA_W(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) bus ();

  fetch_queue #(.DATA_W(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .FREEZE (FREEZE),
    .flush  (flush),
    .fq     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: push/pop applied at the same edge as the DUT
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sb.delete();
    end else if (flush) begin
      sb.delete();
    end else if (!FREEZE) begin
      m_room = (8 - sb.size()) >= 2;
      m_pop  = int'(bus.out_take);
      if (m_pop > 2) m_pop = 2;
      if (m_pop > sb.size()) m_pop = sb.size();
      for (int k = 0; k < m_pop; k++) void'(sb.pop_front());
      if (m_room && bus.in_valid[0]) begin
        sb.push_back({bus.in_instr[31:0], bus.in_pc[31:0]});
        if (bus.in_valid[1]) sb.push_back({bus.in_instr[63:32], bus.in_pc[63:32]});
      end
    end
  end

  // Monitor: compare presented lanes, occupancy and ready against the reference
  always @(negedge CLK) begin
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_i;
    logic [31:0] e_p;
    e_rdy = RESET && !FREEZE && !flush && ((8 - sb.size()) >= 2);
    chk("mon_in_ready", 64'(bus.in_ready), 64'(e_rdy));
    chk("mon_count", 64'(bus.count), 64'(sb.size()));
    for (int i = 0; i < 2; i++) begin
      if (i < sb.size()) begin
        e_v = 1'b1; e_i = sb[i].instr; e_p = sb[i].pc;
      end else begin
        e_v = 1'b0; e_i = '0; e_p = '0;
      end
      chk($sformatf("mon_lane%0d_valid", i), 64'(bus.out_valid[i]), 64'(e_v));
      chk($sformatf("mon_lane%0d_instr", i), 64'(bus.out_instr[i*32 +: 32]), 64'(e_i));
      chk($sformatf("mon_lane%0d_pc", i), 64'(bus.out_pc[i*32 +: 32]), 64'(e_p));
    end
  end

  task automatic idle();
    bus.in_valid = '0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.out_take = '0;
    FREEZE       = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] take,
                       input logic frz, input logic fl);
    bus.in_valid = v;
    bus.in_instr = {i1, i0};
    bus.in_pc    = {p1, p0};
    bus.out_take = take;
    FREEZE       = frz;
    flush        = fl;
    @(posedge CLK);
    #1;
    idle();
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    #1 RESET = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_instr", 64'(bus.out_instr), 64'(0));
    RESET = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rel_count", 64'(bus.count), 64'(0));

    // Fill to eight, then a refused fifth push
    drive(2'b11, 32'h11, 32'h00, 32'h22, 32'h04, 2'd0, 1'b0, 1'b0);
    chk("fill1_valid", 64'(bus.out_valid), 64'(2'b11));
    drive(2'b11, 32'h33, 32'h08, 32'h44, 32'h0C, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 32'h55, 32'h10, 32'h66, 32'h14, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 32'h77, 32'h18, 32'h88, 32'h1C, 2'd0, 1'b0, 1'b0);
    chk("fill_count", 64'(bus.count), 64'(8));
    chk("fill_in_ready", 64'(bus.in_ready), 64'(0));
    drive(2'b11, 32'h99, 32'h20, 32'hAA, 32'h24, 2'd0, 1'b0, 1'b0);
    chk("full_refused_count", 64'(bus.count), 64'(8));
    chk("full_refused_lane0", 64'(bus.out_instr[31:0]), 64'(32'h11));

    // Concurrent push and pop at six entries
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("pop2_count", 64'(bus.count), 64'(6));
    chk("pop2_lane0", 64'(bus.out_instr[31:0]), 64'(32'h33));
    drive(2'b11, 32'h99, 32'h20, 32'hAA, 32'h24, 2'd2, 1'b0, 1'b0);
    chk("conc_count", 64'(bus.count), 64'(6));
    chk("conc_lane0", 64'(bus.out_instr[31:0]), 64'(32'h55));
    chk("conc_lane1", 64'(bus.out_instr[63:32]), 64'(32'h66));

    // Walk head to 7, then pop one and push two across the wrap
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    chk("head7_lane0", 64'(bus.out_instr[31:0]), 64'(32'h88));
    chk("head7_lane1", 64'(bus.out_instr[63:32]), 64'(32'h99));
    drive(2'b11, 32'hBB, 32'h28, 32'hCC, 32'h2C, 2'd1, 1'b0, 1'b0);
    chk("wrap_count", 64'(bus.count), 64'(4));
    chk("wrap_lane0", 64'(bus.out_instr[31:0]), 64'(32'h99));
    chk("wrap_lane1", 64'(bus.out_instr[63:32]), 64'(32'hAA));
    chk("wrap_pc0", 64'(bus.out_pc[31:0]), 64'(32'h20));
    chk("wrap_pc1", 64'(bus.out_pc[63:32]), 64'(32'h24));

    // FREEZE ignores both push and take
    drive(2'b11, 32'hDD, 32'h30, 32'hDE, 32'h34, 2'd2, 1'b1, 1'b0);
    chk("frz_count", 64'(bus.count), 64'(4));
    chk("frz_lane0", 64'(bus.out_instr[31:0]), 64'(32'h99));

    // Flush with FREEZE and a pending push
    bus.in_valid = 2'b11;
    bus.in_instr = {32'hF2, 32'hF1};
    bus.in_pc    = {32'h44, 32'h40};
    bus.out_take = 2'd2;
    FREEZE       = 1'b1;
    flush        = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge CLK);
    #1;
    idle();
    chk("flush_count", 64'(bus.count), 64'(0));
    chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_out_instr", 64'(bus.out_instr), 64'(0));

    // Sparse lanes and clipped take
    drive(2'b10, 32'h01, 32'h40, 32'h02, 32'h44, 2'd0, 1'b0, 1'b0);
    chk("sparse_count", 64'(bus.count), 64'(0));
    drive(2'b01, 32'h01, 32'h40, 32'h02, 32'h44, 2'd0, 1'b0, 1'b0);
    chk("one_count", 64'(bus.count), 64'(1));
    chk("one_lane0", 64'(bus.out_instr[31:0]), 64'(32'h01));
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("clip_count", 64'(bus.count), 64'(0));
    chk("clip_out_valid", 64'(bus.out_valid), 64'(0));
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0);
    chk("empty_take3_count", 64'(bus.count), 64'(0));

    // Head/tail at 1: fill so the last push straddles 7->0, then drain across it
    drive(2'b11, 32'hA0, 32'h100, 32'hA1, 32'h104, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 32'hA2, 32'h108, 32'hA3, 32'h10C, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 32'hA4, 32'h110, 32'hA5, 32'h114, 2'd0, 1'b0, 1'b0);
    drive(2'b11, 32'hA6, 32'h118, 32'hA7, 32'h11C, 2'd0, 1'b0, 1'b0);
    chk("strad_full", 64'(bus.count), 64'(8));
    drive(2'b11, 32'hEE, 32'h200, 32'hEF, 32'h204, 2'd2, 1'b0, 1'b0);
    chk("full_pushpop_count", 64'(bus.count), 64'(6));
    chk("full_pushpop_lane0", 64'(bus.out_instr[31:0]), 64'(32'hA2));
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0);
    chk("take3_count", 64'(bus.count), 64'(4));
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("strad_lane0", 64'(bus.out_instr[31:0]), 64'(32'hA6));
    chk("strad_lane1", 64'(bus.out_instr[63:32]), 64'(32'hA7));
    chk("strad_pc1", 64'(bus.out_pc[63:32]), 64'(32'h11C));
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd3, 1'b0, 1'b0);
    chk("drain_count", 64'(bus.count), 64'(0));

    // Asynchronous reset in the middle of a cycle
    drive(2'b11, 32'h5A, 32'h300, 32'h5B, 32'h304, 2'd0, 1'b0, 1'b0);
    chk("pre_areset_count", 64'(bus.count), 64'(2));
    #2 RESET = 1'b0;
    #1;
    chk("areset_count", 64'(bus.count), 64'(0));
    chk("areset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("areset_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("post_areset_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (2) @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
